sync_cbuf_n: RTL and testbench



---
 rtl/sync_cbuf_n.sv | 185 ++++++++++++++++++
 tb/tb_sync_cbuf_n.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_cbuf_n.sv
// Clocked conditional buffer. It takes dual-rail data tokens with a 1-of-(NOUT+1) control code,
// queues the routed tokens in order, and replays each one as a four-phase handshake on its output channel.
module sync_cbuf_n #(
  parameter int WIDTH = 1,
  parameter int NOUT  = 2,
  parameter int DEPTH = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [2*WIDTH-1:0]        L,
  input  logic [NOUT:0]             C,
  output logic                      Le,
  output logic [NOUT*2*WIDTH-1:0]   R,
  input  logic [NOUT-1:0]           Re,
  output logic [$clog2(DEPTH):0]    count,
  output logic [7:0]                drop_cnt,
  output logic                      err
);
  localparam int DW = 2 * WIDTH;
  localparam int IW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [PW-1:0] PINC_C = PW'(1);

  typedef enum logic {WAIT_DATA = 1'b0, WAIT_NULL = 1'b1} in_state_e;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} out_state_e;

  in_state_e          in_state_q, in_state_d;
  out_state_e         out_state_q, out_state_d;
  logic [DW-1:0]      mem_data_q [DEPTH];
  logic [IW-1:0]      mem_dest_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               err_q, err_d;
  logic [NOUT*DW-1:0] r_q, r_d;

  logic               l_ok_s, l_bad_s, complete_s, neutral_s, illegal_s;
  logic [3:0]         c_ones_s;
  logic [IW-1:0]      c_dest_s;
  logic               accept_s, push_s, drop_s, pop_s, full_s, head_ready_s;
  logic [DW-1:0]      head_data_s;
  logic [IW-1:0]      head_dest_s;

  // Classify the incoming code and decode the destination channel.
  always_comb begin
    l_ok_s   = 1'b1;
    l_bad_s  = 1'b0;
    c_ones_s = 4'd0;
    c_dest_s = IW'(0);
    for (int i = 0; i < WIDTH; i++) begin
      l_ok_s  = l_ok_s & (L[2*i+1] ^ L[2*i]);
      l_bad_s = l_bad_s | (L[2*i+1] & L[2*i]);
    end
    for (int k = 0; k <= NOUT; k++) begin
      c_ones_s = c_ones_s + {3'b000, C[k]};
    end
    for (int k = 0; k < NOUT; k++) begin
      c_dest_s = c_dest_s | (C[k+1] ? IW'(k) : IW'(0));
    end
    complete_s = l_ok_s && (c_ones_s == 4'd1);
    neutral_s  = (L == {DW{1'b0}}) && (C == {(NOUT+1){1'b0}});
    illegal_s  = l_bad_s || (c_ones_s > 4'd1);
  end

  assign full_s       = (count_q == FULL_C);
  assign head_data_s  = mem_data_q[rd_ptr_q];
  assign head_dest_s  = mem_dest_q[rd_ptr_q];
  assign head_ready_s = Re[head_dest_s];

  // Input handshake: accept a complete token, then wait for the neutral phase.
  always_comb begin
    in_state_d = in_state_q;
    err_d      = err_q;
    accept_s   = 1'b0;
    if (illegal_s) begin
      err_d = 1'b1;
    end else begin
      case (in_state_q)
        WAIT_DATA: begin
          if (complete_s && !full_s) begin
            accept_s   = 1'b1;
            in_state_d = WAIT_NULL;
          end else begin
            in_state_d = WAIT_DATA;
          end
        end
        WAIT_NULL: begin
          if (neutral_s && !full_s) begin
            in_state_d = WAIT_DATA;
          end else begin
            in_state_d = WAIT_NULL;
          end
        end
        default: in_state_d = WAIT_DATA;
      endcase
    end
  end

  assign push_s = accept_s & ~C[0];
  assign drop_s = accept_s & C[0];

  // Output handshake: drive the head token, and pop it once its receiver drops enable.
  always_comb begin
    out_state_d = out_state_q;
    r_d         = r_q;
    pop_s       = 1'b0;
    case (out_state_q)
      IDLE: begin
        if ((count_q != {CW{1'b0}}) && head_ready_s) begin
          r_d = {(NOUT*DW){1'b0}};
          r_d[head_dest_s*DW +: DW] = head_data_s;
          out_state_d = SEND;
        end else begin
          out_state_d = IDLE;
        end
      end
      SEND: begin
        if (!head_ready_s) begin
          r_d         = {(NOUT*DW){1'b0}};
          pop_s       = 1'b1;
          out_state_d = IDLE;
        end else begin
          out_state_d = SEND;
        end
      end
      default: begin
        r_d         = {(NOUT*DW){1'b0}};
        out_state_d = IDLE;
      end
    endcase
  end

  // Pointer, occupancy and drop-counter updates.
  always_comb begin
    wr_ptr_d   = push_s ? (wr_ptr_q + PINC_C) : wr_ptr_q;
    rd_ptr_d   = pop_s ? (rd_ptr_q + PINC_C) : rd_ptr_q;
    drop_cnt_d = (drop_s && (drop_cnt_q != 8'hFF)) ? (drop_cnt_q + 8'd1) : drop_cnt_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_state_q  <= WAIT_DATA;
      out_state_q <= IDLE;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      drop_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      r_q         <= {(NOUT*DW){1'b0}};
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      err_q       <= err_d;
      r_q         <= r_d;
    end
  end

  // Token storage; contents are only meaningful behind valid pointers.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_data_q[wr_ptr_q] <= L;
      mem_dest_q[wr_ptr_q] <= c_dest_s;
    end
  end

  assign Le       = (in_state_q == WAIT_DATA);
  assign R        = r_q;
  assign count    = count_q;
  assign drop_cnt = drop_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sync_cbuf_n.sv
// Self-checking bench for sync_cbuf_n. A queue-based reference model is compared every cycle,
// and directed literal checks cover the handshake scenarios.
module tb_sync_cbuf_n;
  localparam int WIDTH = 1;
  localparam int NOUT  = 2;
  localparam int DEPTH = 2;
  localparam int DW    = 2 * WIDTH;

  logic                    CLK;
  logic                    RESET;
  logic [DW-1:0]           L;
  logic [NOUT:0]           C;
  logic                    Le;
  logic [NOUT*DW-1:0]      R;
  logic [NOUT-1:0]         Re;
  logic [$clog2(DEPTH):0]  count;
  logic [7:0]              drop_cnt;
  logic                    err;

  sync_cbuf_n #(.WIDTH(WIDTH), .NOUT(NOUT), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .L(L), .C(C), .Le(Le), .R(R), .Re(Re),
    .count(count), .drop_cnt(drop_cnt), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] data;
    int            dest;
  } tok_t;

  tok_t               q[$];
  bit                 m_le, m_send, m_err;
  int                 m_drop;
  logic [NOUT*DW-1:0] m_r;
  int                 vectors, miscompares;

  function automatic bit is_illegal(input logic [DW-1:0] l, input logic [NOUT:0] c);
    bit bad = ($countones(c) > 1);
    for (int i = 0; i < WIDTH; i++) if (l[2*i +: 2] == 2'b11) bad = 1'b1;
    return bad;
  endfunction

  function automatic bit is_complete(input logic [DW-1:0] l, input logic [NOUT:0] c);
    bit ok = ($countones(c) == 1);
    for (int i = 0; i < WIDTH; i++) if ($countones(l[2*i +: 2]) != 1) ok = 1'b0;
    return ok;
  endfunction

  function automatic int dest_of(input logic [NOUT:0] c);
    int d = 0;
    for (int k = 0; k < NOUT; k++) if (c[k+1]) d = k;
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs currently applied.
  task automatic model_step();
    tok_t t;
    int   cnt;
    bit   pop;
    pop = 1'b0;
    if (RESET) begin
      m_le = 1'b1; m_send = 1'b0; m_err = 1'b0; m_drop = 0; m_r = '0;
      q.delete();
      return;
    end
    cnt = q.size();
    if (m_send) begin
      if (!Re[q[0].dest]) begin
        m_r = '0; m_send = 1'b0; pop = 1'b1;
      end
    end else if (cnt > 0 && Re[q[0].dest]) begin
      m_r = '0;
      m_r[q[0].dest*DW +: DW] = q[0].data;
      m_send = 1'b1;
    end
    if (is_illegal(L, C)) begin
      m_err = 1'b1;
    end else if (m_le) begin
      if (is_complete(L, C) && cnt < DEPTH) begin
        m_le = 1'b0;
        if (C[0]) begin
          if (m_drop < 255) m_drop++;
        end else begin
          t.data = L;
          t.dest = dest_of(C);
          q.push_back(t);
        end
      end
    end else if (L == '0 && C == '0 && cnt < DEPTH) begin
      m_le = 1'b1;
    end
    if (pop) void'(q.pop_front());
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    chk("Le", {31'd0, Le}, {31'd0, m_le});
    chk("R", 32'(R), 32'(m_r));
    chk("count", 32'(count), q.size());
    chk("drop_cnt", 32'(drop_cnt), m_drop);
    chk("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic drive(input logic [DW-1:0] l, input logic [NOUT:0] c, input logic [NOUT-1:0] re);
    L = l; C = c; Re = re;
    step();
  endtask

  initial begin
    logic [NOUT:0] one_c;
    int r;
    vectors = 0; miscompares = 0;
    m_le = 1'b1; m_send = 1'b0; m_err = 1'b0; m_drop = 0; m_r = '0;
    one_c = 1;
    RESET = 1'b1; L = '0; C = '0; Re = '0;
    step(); step();
    RESET = 1'b0;
    chk("rst_le", {31'd0, Le}, 32'd1);
    chk("rst_r", 32'(R), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    // Basic route to out0
    drive(2'b01, 3'b010, 2'b11);
    chk("t1_le", {31'd0, Le}, 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    drive(2'b00, 3'b000, 2'b11);
    chk("t1_r", 32'(R), 32'h1);
    drive(2'b00, 3'b000, 2'b10);
    chk("t1_pop_r", 32'(R), 32'd0);
    chk("t1_pop_count", 32'(count), 32'd0);

    // Drop token
    drive(2'b10, 3'b001, 2'b00);
    chk("t2_drop", 32'(drop_cnt), 32'd1);
    chk("t2_le", {31'd0, Le}, 32'd0);
    drive(2'b00, 3'b000, 2'b00);
    chk("t2_le_back", {31'd0, Le}, 32'd1);

    // Full and backpressure
    drive(2'b01, 3'b100, 2'b00);
    drive(2'b00, 3'b000, 2'b00);
    drive(2'b10, 3'b100, 2'b00);
    chk("t3_full", 32'(count), 32'd2);
    drive(2'b00, 3'b000, 2'b00);
    chk("t3_le_full", {31'd0, Le}, 32'd0);
    drive(2'b01, 3'b100, 2'b00);
    drive(2'b01, 3'b100, 2'b10);
    chk("t3_first", 32'(R), 32'h4);
    drive(2'b01, 3'b100, 2'b00);
    chk("t3_pop", 32'(count), 32'd1);
    drive(2'b00, 3'b000, 2'b00);
    chk("t3_le_up", {31'd0, Le}, 32'd1);
    drive(2'b01, 3'b100, 2'b00);
    drive(2'b00, 3'b000, 2'b10);
    chk("t3_second", 32'(R), 32'h8);
    drive(2'b00, 3'b000, 2'b00);
    drive(2'b00, 3'b000, 2'b10);
    chk("t3_third", 32'(R), 32'h4);
    drive(2'b00, 3'b000, 2'b00);

    // Illegal codes
    drive(2'b11, 3'b010, 2'b00);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_count", 32'(count), 32'd0);
    drive(2'b01, 3'b110, 2'b00);
    chk("t4_err_hold", {31'd0, err}, 32'd1);
    chk("t4_noacc", {31'd0, Le}, 32'd1);
    RESET = 1'b1;
    drive(2'b00, 3'b000, 2'b00);
    RESET = 1'b0;
    chk("t4_err_clr", {31'd0, err}, 32'd0);

    // Head-of-line blocking
    drive(2'b01, 3'b010, 2'b10);
    drive(2'b00, 3'b000, 2'b10);
    drive(2'b10, 3'b100, 2'b10);
    drive(2'b00, 3'b000, 2'b10);
    chk("t5_blocked", 32'(R), 32'd0);
    chk("t5_count", 32'(count), 32'd2);
    drive(2'b00, 3'b000, 2'b11);
    chk("t5_out0", 32'(R), 32'h1);
    drive(2'b00, 3'b000, 2'b10);
    chk("t5_gap", 32'(R), 32'd0);
    drive(2'b00, 3'b000, 2'b10);
    chk("t5_out1", 32'(R), 32'h8);
    drive(2'b00, 3'b000, 2'b00);

    // Reset mid-transfer
    drive(2'b01, 3'b010, 2'b00);
    drive(2'b00, 3'b000, 2'b00);
    drive(2'b10, 3'b010, 2'b00);
    drive(2'b00, 3'b000, 2'b00);
    drive(2'b00, 3'b000, 2'b01);
    chk("t6_send", 32'(R), 32'h1);
    chk("t6_count", 32'(count), 32'd2);
    RESET = 1'b1;
    drive(2'b00, 3'b000, 2'b01);
    RESET = 1'b0;
    chk("t6_r", 32'(R), 32'd0);
    chk("t6_count0", 32'(count), 32'd0);
    chk("t6_le", {31'd0, Le}, 32'd1);

    // Drop counter saturation
    for (int n = 0; n < 256; n++) begin
      drive(2'b10, 3'b001, 2'b00);
      drive(2'b00, 3'b000, 2'b00);
    end
    chk("t6_sat", 32'(drop_cnt), 32'd255);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      RESET = ($urandom_range(0, 199) == 0);
      Re = NOUT'($urandom);
      if (r < 40) begin
        L = '0; C = '0;
      end else if (r < 88) begin
        for (int i = 0; i < WIDTH; i++) L[2*i +: 2] = $urandom_range(0, 1) ? 2'b10 : 2'b01;
        C = one_c << $urandom_range(0, NOUT);
      end else if (r < 96) begin
        L = '0;
        C = one_c << $urandom_range(0, NOUT);
      end else begin
        L = DW'($urandom);
        C = (NOUT+1)'($urandom);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
